// File: rtl/vote_tally.sv
// ============================================================================
// Module   : vote_tally
// Purpose  : Weighted-vote tallier. Scans ballots chunk by chunk and keeps a
//            saturating signed yes-minus-no margin per session.
//            Optional feature macro: VOTE_VETO_EN (VVIP acts as a veto).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vote_tally #(
    parameter int NP_N   = 32,
    parameter int CHUNK  = 8,
    parameter int VIP_N  = 8,
    parameter int NP_W   = 1,
    parameter int VIP_W  = 4,
    parameter int VVIP_W = 16,
    parameter int RES_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NP_N-1:0]         np,
    input  logic [VIP_N-1:0]        vip,
    input  logic                    vvip,
    input  logic                    close,
    output logic                    busy,
    output logic signed [RES_W-1:0] res,
    output logic                    res_valid,
    output logic [1:0]              winner,
    output logic                    overflow
);

    localparam int c_nchunk = NP_N / CHUNK;
    localparam int c_cw     = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;
    localparam int c_iw     = RES_W + 2;
    localparam logic signed [c_iw-1:0] c_max = {3'b000, {(RES_W-1){1'b1}}};
    localparam logic signed [c_iw-1:0] c_min = {3'b111, {(RES_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPEN = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [NP_N-1:0]         r_np;
    logic [VIP_N-1:0]        r_vip;
    logic                    r_vvip;
    logic [c_cw-1:0]         r_cnt;
    logic signed [c_iw-1:0]  r_part;
    logic signed [RES_W-1:0] r_acc;
    logic                    r_ovf;
    logic                    r_close_pend;
    logic signed [RES_W-1:0] r_res;
    logic [1:0]              r_win;

    logic                    w_last;
    logic                    w_veto;
    logic                    w_veto_nxt;
    logic signed [c_iw-1:0]  w_chunk_term;
    logic signed [c_iw-1:0]  w_vip_term;
    logic signed [c_iw-1:0]  w_vvip_term;
    logic signed [c_iw-1:0]  w_sum;
    logic signed [c_iw-1:0]  w_acc_ext;
    logic signed [c_iw-1:0]  w_fold;
    logic signed [RES_W-1:0] w_sat;
    logic                    w_clamp;

    function automatic int f_ones_chunk(input logic [CHUNK-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < CHUNK; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int f_ones_vip(input logic [VIP_N-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < VIP_N; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic logic [1:0] f_winner(input logic signed [RES_W-1:0] v,
                                            input logic veto);
        logic [1:0] w;
        if (veto)        w = 2'b10;
        else if (v > 0)  w = 2'b01;
        else if (v < 0)  w = 2'b10;
        else             w = 2'b11;
        return w;
    endfunction

    assign w_last       = (r_cnt == c_cw'(c_nchunk - 1));
    // r_np shifts right each SCAN cycle, so the low chunk is always the current one
    assign w_chunk_term = c_iw'(NP_W * (2 * f_ones_chunk(r_np[CHUNK-1:0]) - CHUNK));
    assign w_vip_term   = c_iw'(VIP_W * (2 * f_ones_vip(r_vip) - VIP_N));

`ifdef VOTE_VETO_EN
    logic r_veto;
    assign w_veto      = r_veto;
    assign w_veto_nxt  = r_veto | ~r_vvip;
    assign w_vvip_term = '0;
`else
    assign w_veto      = 1'b0;
    assign w_veto_nxt  = 1'b0;
    assign w_vvip_term = r_vvip ? c_iw'(VVIP_W) : c_iw'(-VVIP_W);
`endif

    assign w_sum     = r_part + w_chunk_term + w_vip_term + w_vvip_term;
    assign w_acc_ext = {{2{r_acc[RES_W-1]}}, r_acc};
    assign w_fold    = w_acc_ext + w_sum;

    always_comb begin
        w_sat   = w_fold[RES_W-1:0];
        w_clamp = 1'b0;
        if (w_fold > c_max) begin
            w_sat   = c_max[RES_W-1:0];
            w_clamp = 1'b1;
        end else if (w_fold < c_min) begin
            w_sat   = c_min[RES_W-1:0];
            w_clamp = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = S_OPEN;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_IDLE;
                S_OPEN: begin
                    if (in_valid)   w_state_nxt = S_SCAN;
                    else if (close) w_state_nxt = S_DONE;
                end
                S_SCAN: begin
                    if (w_last) w_state_nxt = r_close_pend ? S_DONE : S_OPEN;
                end
                S_DONE: w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_np         <= '0;
            r_vip        <= '0;
            r_vvip       <= 1'b0;
            r_cnt        <= '0;
            r_part       <= '0;
            r_acc        <= '0;
            r_ovf        <= 1'b0;
            r_close_pend <= 1'b0;
            r_res        <= '0;
            r_win        <= 2'b00;
`ifdef VOTE_VETO_EN
            r_veto       <= 1'b0;
`endif
        end else if (start) begin
            // res/winner deliberately survive an abort or a new session
            r_acc        <= '0;
            r_ovf        <= 1'b0;
            r_close_pend <= 1'b0;
`ifdef VOTE_VETO_EN
            r_veto       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_OPEN: begin
                    if (in_valid) begin
                        r_np         <= np;
                        r_vip        <= vip;
                        r_vvip       <= vvip;
                        r_cnt        <= '0;
                        r_part       <= '0;
                        r_close_pend <= close;
                    end else if (close) begin
                        r_res <= r_acc;
                        r_win <= f_winner(r_acc, w_veto);
                    end
                end
                S_SCAN: begin
                    r_np   <= r_np >> CHUNK;
                    r_cnt  <= r_cnt + 1'b1;
                    r_part <= r_part + w_chunk_term;
                    if (w_last) begin
                        r_acc        <= w_sat;
                        r_ovf        <= r_ovf | w_clamp;
                        r_close_pend <= 1'b0;
`ifdef VOTE_VETO_EN
                        r_veto       <= w_veto_nxt;
`endif
                        if (r_close_pend) begin
                            r_res <= w_sat;
                            r_win <= f_winner(w_sat, w_veto_nxt);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_OPEN);
    assign busy      = (r_state == S_OPEN) || (r_state == S_SCAN);
    assign res_valid = (r_state == S_DONE);
    assign res       = r_res;
    assign winner    = r_win;
    assign overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_vote_tally.sv
// Directed bench for vote_tally: default instance plus an RES_W=8 instance
// sharing the same stimulus. Expectations follow VOTE_VETO_EN when defined.
`default_nettype none

module tb_vote_tally;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [31:0] np;
    logic [7:0]  vip;
    logic        vvip;
    logic        close;

    logic        in_ready, busy, res_valid, overflow;
    logic [15:0] res;
    logic [1:0]  winner;
    logic        in_ready8, busy8, res_valid8, overflow8;
    logic [7:0]  res8;
    logic [1:0]  winner8;

    int total = 0;
    int bad   = 0;
    int seen;

`ifdef VOTE_VETO_EN
    localparam logic [15:0] E1_RES  = 16'hffe0;   // -32
    localparam logic [7:0]  E1_RES8 = 8'he0;
    localparam logic [15:0] E2_RES  = 16'h0080;   // 128
    localparam logic [1:0]  E3_WIN  = 2'b10;
    localparam logic [15:0] E7A_RES = 16'h0040;   // 64
    localparam logic [1:0]  E7A_WIN = 2'b10;
    localparam logic [15:0] E7B_RES = 16'h0040;
`else
    localparam logic [15:0] E1_RES  = 16'hfff0;   // -16
    localparam logic [7:0]  E1_RES8 = 8'hf0;
    localparam logic [15:0] E2_RES  = 16'h00a0;   // 160
    localparam logic [1:0]  E3_WIN  = 2'b11;
    localparam logic [15:0] E7A_RES = 16'h0030;   // 48
    localparam logic [1:0]  E7A_WIN = 2'b01;
    localparam logic [15:0] E7B_RES = 16'h0050;   // 80
`endif

    vote_tally dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .np(np), .vip(vip), .vvip(vvip), .close(close),
        .busy(busy), .res(res), .res_valid(res_valid), .winner(winner),
        .overflow(overflow)
    );

    vote_tally #(.RES_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready8), .np(np), .vip(vip), .vvip(vvip), .close(close),
        .busy(busy8), .res(res8), .res_valid(res_valid8), .winner(winner8),
        .overflow(overflow8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // called at a negedge in OPEN; returns at the negedge where OPEN is back
    task automatic ballot(input logic [31:0] n, input logic [7:0] v, input logic vv);
        np = n; vip = v; vvip = vv; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic do_close();
        close = 1'b1;
        tick();
        close = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; close = 1'b0;
        np = '0; vip = '0; vvip = 1'b0;
        repeat (3) tick();

        chk("rst_in_ready",  32'(in_ready),  32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_res",       32'(res),       32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_winner",    32'(winner),    32'h0);
        chk("rst_overflow",  32'(overflow),  32'h0);
        chk("rst_in_ready8", 32'(in_ready8), 32'h0);
        chk("rst_busy8",     32'(busy8),     32'h0);
        rst_n = 1'b1;
        tick();

        // single ballot, then close in OPEN
        pulse_start();
        chk("open_in_ready", 32'(in_ready), 32'h1);
        chk("open_busy",     32'(busy),     32'h1);
        np = 32'h0ca800c8; vip = 8'h05; vvip = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("scan_in_ready", 32'(in_ready), 32'h0);
            tick();
        end
        chk("post_scan_in_ready", 32'(in_ready), 32'h1);
        do_close();
        chk("t1_res_valid",  32'(res_valid),  32'h1);
        chk("t1_res",        32'(res),        32'(E1_RES));
        chk("t1_winner",     32'(winner),     32'h2);
        chk("t1_res8",       32'(res8),       32'(E1_RES8));
        chk("t1_res_valid8", 32'(res_valid8), 32'h1);
        tick();
        chk("t1_strobe_end", 32'(res_valid), 32'h0);
        chk("t1_idle_busy",  32'(busy),      32'h0);
        chk("t1_res_hold",   32'(res),       32'(E1_RES));

        // two all-yes ballots; the 8-bit instance saturates
        pulse_start();
        ballot(32'hffffffff, 8'hff, 1'b1);
        ballot(32'hffffffff, 8'hff, 1'b1);
        do_close();
        chk("t2_res",       32'(res),       32'(E2_RES));
        chk("t2_winner",    32'(winner),    32'h1);
        chk("t2_overflow",  32'(overflow),  32'h0);
        chk("t2_res8",      32'(res8),      32'h7f);
        chk("t2_overflow8", 32'(overflow8), 32'h1);
        chk("t2_winner8",   32'(winner8),   32'h1);
        tick();
        pulse_start();
        chk("t2_ovf8_cleared", 32'(overflow8), 32'h0);

        // opposite VVIP votes cancel
        ballot(32'h0000ffff, 8'h0f, 1'b1);
        ballot(32'h0000ffff, 8'h0f, 1'b0);
        do_close();
        chk("t3_res",    32'(res),    32'h0);
        chk("t3_winner", 32'(winner), 32'(E3_WIN));
        tick();

        // ballot and close in the same cycle
        pulse_start();
        np = 32'h0ca800c8; vip = 8'h05; vvip = 1'b1; in_valid = 1'b1; close = 1'b1;
        tick();
        in_valid = 1'b0; close = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t4_no_early_strobe", 32'(res_valid), 32'h0);
            tick();
        end
        chk("t4_res_valid", 32'(res_valid), 32'h1);
        chk("t4_res",       32'(res),       32'(E1_RES));
        tick();

        // start during SCAN discards the ballot
        pulse_start();
        np = 32'hffffffff; vip = 8'hff; vvip = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        pulse_start();
        chk("t5_in_ready", 32'(in_ready), 32'h1);
        do_close();
        chk("t5_res_valid", 32'(res_valid), 32'h1);
        chk("t5_res",       32'(res),       32'h0);
        chk("t5_winner",    32'(winner),    32'h3);
        tick();

        // reset mid-SCAN: everything clears and no strobe follows
        pulse_start();
        np = 32'hffffffff; vip = 8'hff; vvip = 1'b1; in_valid = 1'b1; close = 1'b1;
        tick();
        in_valid = 1'b0; close = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_res",      32'(res),      32'h0);
        chk("t6_winner",   32'(winner),   32'h0);
        chk("t6_busy",     32'(busy),     32'h0);
        chk("t6_in_ready", 32'(in_ready), 32'h0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            tick();
            if (res_valid) seen = 1;
        end
        chk("t6_no_strobe", 32'(seen), 32'h0);

        // VVIP no-vote, then yes-vote
        pulse_start();
        ballot(32'hffffffff, 8'hff, 1'b0);
        do_close();
        chk("t7a_res",    32'(res),    32'(E7A_RES));
        chk("t7a_winner", 32'(winner), 32'(E7A_WIN));
        tick();
        pulse_start();
        ballot(32'hffffffff, 8'hff, 1'b1);
        do_close();
        chk("t7b_res",    32'(res),    32'(E7B_RES));
        chk("t7b_winner", 32'(winner), 32'h1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
